// File: rtl/regulation_test_seq.sv
// Test-mode sequencer: raises enable_regulation, waits for ok_regulation, drives tmi,
// settles, then serially captures tdo and returns it through a valid/ready response.
module regulation_test_seq #(
  parameter int CAP_WIDTH      = 16,
  parameter int SETTLE_CYCLES  = 16,
  parameter int SAMPLE_DIV     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [4:0]                     cmd_mode,
  input  logic [$clog2(CAP_WIDTH+1)-1:0] cmd_len,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [CAP_WIDTH-1:0]           rsp_data,
  output logic                           rsp_timeout,
  output logic [4:0]                     tmi,
  input  logic                           tdo,
  output logic                           enable_regulation,
  input  logic                           ok_regulation,
  output logic                           busy
);

  localparam int LW = $clog2(CAP_WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int DW = $clog2(SAMPLE_DIV + 1);

  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(SAMPLE_DIV - 1);
  localparam logic [LW-1:0] LEN_MAX     = LW'(CAP_WIDTH);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAIT_OK = 3'd1;
  localparam logic [2:0] SETMODE = 3'd2;
  localparam logic [2:0] SETTLE  = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] RELEASE = 3'd5;
  localparam logic [2:0] RESP    = 3'd6;

  logic [2:0]           state;
  logic [4:0]           mode;
  logic [LW-1:0]        len;
  logic [LW-1:0]        bitcnt;
  logic [TW-1:0]        timer;
  logic [SW-1:0]        settle_cnt;
  logic [DW-1:0]        div_cnt;
  logic [CAP_WIDTH-1:0] shift_reg;
  logic                 ok_meta, ok_s;
  logic                 tdo_meta, tdo_s;

  assign busy = (state != IDLE);

  // Two-flop synchronizers for the asynchronous status and data inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_meta  <= 1'b0;
      ok_s     <= 1'b0;
      tdo_meta <= 1'b0;
      tdo_s    <= 1'b0;
    end else begin
      ok_meta  <= ok_regulation;
      ok_s     <= ok_meta;
      tdo_meta <= tdo;
      tdo_s    <= tdo_meta;
    end
  end

  // Sequencer state machine and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      mode              <= 5'd0;
      len               <= '0;
      bitcnt            <= '0;
      timer             <= '0;
      settle_cnt        <= '0;
      div_cnt           <= '0;
      shift_reg         <= '0;
      cmd_ready         <= 1'b0;
      rsp_valid         <= 1'b0;
      rsp_data          <= '0;
      rsp_timeout       <= 1'b0;
      tmi               <= 5'd0;
      enable_regulation <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            mode              <= cmd_mode;
            len               <= (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
            shift_reg         <= '0;
            timer             <= '0;
            enable_regulation <= 1'b1;
            cmd_ready         <= 1'b0;
            state             <= WAIT_OK;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WAIT_OK: begin
          timer <= timer + TW'(1);
          // ok_s is tested first so it wins over a coincident timeout
          if (ok_s) begin
            state <= SETMODE;
          end else if (timer == TIMER_LAST) begin
            rsp_timeout <= 1'b1;
            shift_reg   <= '0;
            state       <= RELEASE;
          end else begin
            state <= WAIT_OK;
          end
        end
        SETMODE: begin
          tmi        <= mode;
          settle_cnt <= '0;
          div_cnt    <= '0;
          bitcnt     <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= (len == LW'(0)) ? RELEASE : CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        CAPTURE: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            shift_reg <= {shift_reg[CAP_WIDTH-2:0], tdo_s};
            bitcnt    <= bitcnt + LW'(1);
            if ((bitcnt + LW'(1)) == len) begin
              state <= RELEASE;
            end else begin
              state <= CAPTURE;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        RELEASE: begin
          tmi               <= 5'd0;
          enable_regulation <= 1'b0;
          rsp_data          <= shift_reg;
          rsp_valid         <= 1'b1;
          state             <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            cmd_ready   <= 1'b1;
            state       <= IDLE;
          end else begin
            state <= RESP;
          end
        end
        default: begin
          tmi               <= 5'd0;
          enable_regulation <= 1'b0;
          rsp_valid         <= 1'b0;
          cmd_ready         <= 1'b0;
          state             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regulation_test_seq.sv
// Scoreboard bench for regulation_test_seq: stimulus pushes expected responses,
// a negedge monitor pops and compares them on each response handshake.
module tb_regulation_test_seq;

  localparam int CW = 16;
  localparam int LW = 5;
  localparam int TIMEOUT = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [4:0]    cmd_mode;
  logic [LW-1:0] cmd_len;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [CW-1:0] rsp_data;
  logic          rsp_timeout;
  logic [4:0]    tmi;
  logic          tdo;
  logic          enable_regulation;
  logic          ok_regulation;
  logic          busy;

  typedef struct packed {
    logic [CW-1:0] data;
    logic          to;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  regulation_test_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .tmi(tmi), .tdo(tdo), .enable_regulation(enable_regulation),
    .ok_regulation(ok_regulation), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every response handshake against the scoreboard head
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got data 0x%0h, expected no response", rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        check("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.to));
      end
    end
  end

  task automatic issue(input logic [4:0] mode, input logic [LW-1:0] len);
    int n;
    n = 0;
    cmd_mode  = mode;
    cmd_len   = len;
    cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 100);
    if (!cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL cmd_accept: got cmd_ready=0, expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // One full command; tdo bits go MSB-first, each held across its sample window
  task automatic run(input string name, input logic [4:0] mode, input logic [LW-1:0] len,
                     input logic [31:0] pat, input int nbits, input logic [CW-1:0] exp_data,
                     input int exp_lat, input bit hold);
    int n;
    exp_q.push_back({exp_data, 1'b0});
    issue(mode, len);
    repeat (10) @(posedge clk);
    #1 check({name, "_tmi_settle"}, 32'(tmi), 32'(mode));
    repeat (8) @(posedge clk);
    #1 n = 18;
    for (int k = 0; k < nbits; k++) begin
      tdo = pat[nbits-1-k];
      if (k == 0) check({name, "_tmi_capture"}, 32'(tmi), 32'(mode));
      repeat (4) @(posedge clk);
      #1 n += 4;
    end
    while (!rsp_valid && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
    tdo = 1'b0;
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    check({name, "_tmi_released"}, 32'(tmi), 32'd0);
    check({name, "_enable_released"}, 32'(enable_regulation), 32'd0);
    if (hold) begin
      rsp_ready = 1'b0;
      cmd_mode  = 5'h1A;
      cmd_len   = 5'd2;
      cmd_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1;
        check({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
        check({name, "_hold_data"}, 32'(rsp_data), 32'(exp_data));
        check({name, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({name, "_valid_cleared"}, 32'(rsp_valid), 32'd0);
    check({name, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int n;
    int en_cnt;
    int bad_tmi;
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 5'd0; cmd_len = '0;
    rsp_ready = 1'b1; tdo = 1'b0; ok_regulation = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tmi", 32'(tmi), 32'd0);
    check("reset_enable", 32'(enable_regulation), 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 1+1+16+len*4+1 cycles from accept to rsp_valid
    run("basic", 5'h0B, 5'd8, 32'hB2, 8, 16'h00B2, 51, 1'b0);
    run("len0", 5'h1F, 5'd0, 32'h0, 0, 16'h0000, 19, 1'b0);
    run("clamp", 5'h03, 5'd31, 32'hFFFF, 16, 16'hFFFF, 83, 1'b0);
    run("hold", 5'h05, 5'd4, 32'hA, 4, 16'h000A, 35, 1'b1);

    // ok never seen: timer expires after TIMEOUT cycles in WAIT_OK, then RELEASE
    ok_regulation = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    exp_q.push_back({16'h0000, 1'b1});
    issue(5'h07, 5'd4);
    n = 0; en_cnt = 0; bad_tmi = 0;
    while (!rsp_valid && n < 3000) begin
      if (enable_regulation) en_cnt++;
      if (tmi != 5'd0) bad_tmi++;
      @(posedge clk);
      #1 n++;
    end
    check("timeout_latency", 32'(n), 32'(TIMEOUT + 1));
    check("timeout_enable_cycles", 32'(en_cnt), 32'(TIMEOUT + 1));
    check("timeout_tmi_idle", 32'(bad_tmi), 32'd0);
    check("timeout_flag", 32'(rsp_timeout), 32'd1);
    @(posedge clk);
    #1 check("timeout_cmd_ready_after", 32'(cmd_ready), 32'd1);
    ok_regulation = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of capture aborts with no response
    issue(5'h0B, 5'd8);
    repeat (30) @(posedge clk);
    #1 check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_tmi", 32'(tmi), 32'd0);
    check("abort_enable", 32'(enable_regulation), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    run("after_reset", 5'h12, 5'd3, 32'h6, 3, 16'h0006, 31, 1'b0);

    repeat (5) @(posedge clk);
    #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
